// File: rtl/raster_stream_source_pkg.sv
// Shared video definitions: default raster geometry, pixel width, raster
// position type and the stream source state encoding.
package raster_stream_source_pkg;

    localparam int VID_DATA_WIDTH = 8;
    localparam int VID_H_ACTIVE   = 400;
    localparam int VID_H_TOTAL    = 420;
    localparam int VID_V_ACTIVE   = 300;
    localparam int VID_V_TOTAL    = 320;

    // Counter width for x/y; covers any geometry up to 65535 positions per axis.
    localparam int POS_W = 16;

    typedef struct packed {
        logic [POS_W-1:0] y;
        logic [POS_W-1:0] x;
    } raster_pos_t;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } src_state_t;

    // True at the first position of a frame.
    function automatic logic is_origin(raster_pos_t p);
        return (p.x == '0) && (p.y == '0);
    endfunction

endpackage

// File: rtl/raster_counter.sv
// Raster x/y position counters. Advances one position per 'advance' pulse,
// wrapping at the end of each line and frame, and flags whether the current
// position is active and whether it is the last position of the frame.
module raster_counter
    import raster_stream_source_pkg::*;
#(
    parameter int H_ACTIVE = VID_H_ACTIVE,
    parameter int H_TOTAL  = VID_H_TOTAL,
    parameter int V_ACTIVE = VID_V_ACTIVE,
    parameter int V_TOTAL  = VID_V_TOTAL
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             advance,
    output logic [POS_W-1:0] x,
    output logic [POS_W-1:0] y,
    output logic             active,
    output logic             last_pos
);

    localparam logic [POS_W-1:0] X_ACT  = POS_W'(H_ACTIVE);
    localparam logic [POS_W-1:0] X_LAST = POS_W'(H_TOTAL - 1);
    localparam logic [POS_W-1:0] Y_ACT  = POS_W'(V_ACTIVE);
    localparam logic [POS_W-1:0] Y_LAST = POS_W'(V_TOTAL - 1);

    raster_pos_t pos;

    // Position register: step x, carry into y at end of line, wrap at end of frame.
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pos <= '0;
        end else if (advance) begin
            if (pos.x == X_LAST) begin
                pos.x <= '0;
                pos.y <= (pos.y == Y_LAST) ? '0 : pos.y + 1'b1;
            end else begin
                pos.x <= pos.x + 1'b1;
            end
        end
    end

    assign x        = pos.x;
    assign y        = pos.y;
    assign active   = (pos.x < X_ACT) && (pos.y < Y_ACT);
    assign last_pos = (pos.x == X_LAST) && (pos.y == Y_LAST);

endmodule

// File: rtl/raster_stream_source.sv
// Blanked raster stream source. Pulls active pixels from an upstream
// ready/valid source, inserts horizontal/vertical blanking beats, and
// withdraws validout (freezing position) when upstream starves mid-frame.
module raster_stream_source
    import raster_stream_source_pkg::*;
#(
    parameter int DATA_WIDTH = VID_DATA_WIDTH,
    parameter int H_ACTIVE   = VID_H_ACTIVE,
    parameter int H_TOTAL    = VID_H_TOTAL,
    parameter int V_ACTIVE   = VID_V_ACTIVE,
    parameter int V_TOTAL    = VID_V_TOTAL,
    parameter int STALL_W    = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [DATA_WIDTH-1:0] pix_in,
    input  logic                  pix_in_valid,
    output logic                  pix_in_ready,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  blanking_out,
    output logic                  validout,
    output logic                  sof,
    output logic                  eof,
    output logic                  busy,
    output logic [STALL_W-1:0]    stall_cycles
);

    src_state_t       state;
    src_state_t       state_nxt;
    logic [POS_W-1:0] x_pos;
    logic [POS_W-1:0] y_pos;
    logic             pos_active;
    logic             pos_last;
    logic             advance;
    logic             stall;
    logic             at_origin;
    raster_pos_t      pos;

    raster_counter #(
        .H_ACTIVE (H_ACTIVE),
        .H_TOTAL  (H_TOTAL),
        .V_ACTIVE (V_ACTIVE),
        .V_TOTAL  (V_TOTAL)
    ) u_counter (
        .clock    (clock),
        .reset    (reset),
        .advance  (advance),
        .x        (x_pos),
        .y        (y_pos),
        .active   (pos_active),
        .last_pos (pos_last)
    );

    assign pos.x     = x_pos;
    assign pos.y     = y_pos;
    assign at_origin = is_origin(pos);

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state plus handshake/advance decode; frames end only on their last beat.
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_nxt    = state;
        pix_in_ready = 1'b0;
        advance      = 1'b0;
        stall        = 1'b0;
        case (state)
            ST_IDLE: begin
                if (enable) begin
                    state_nxt = ST_STREAM;
                end
            end
            ST_STREAM: begin
                pix_in_ready = pos_active;
                advance      = !pos_active || pix_in_valid;
                stall        = pos_active && !pix_in_valid;
                if (advance && pos_last && !enable) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Output register: emit a pixel or blank beat on advance, hold data on stalls.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            dout         <= '0;
            blanking_out <= 1'b0;
            validout     <= 1'b0;
            sof          <= 1'b0;
            eof          <= 1'b0;
        end else begin
            validout <= advance;
            sof      <= advance && at_origin;
            eof      <= advance && pos_last;
            if (advance) begin
                dout         <= pos_active ? pix_in : '0;
                blanking_out <= !pos_active;
            end
        end
    end

    // Stall counter: cleared with the frame's first beat, saturates at all-ones.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stall_cycles <= '0;
        end else if (advance && at_origin) begin
            stall_cycles <= '0;
        end else if (stall && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + 1'b1;
        end
    end

    assign busy = (state == ST_STREAM);

endmodule

// File: tb/tb_raster_stream_source.sv
// Randomized scoreboard bench for raster_stream_source on a reduced geometry.
// The frame model pushes the expected beat stream per frame; a monitor pops
// and compares every beat the DUT presents.
module tb_raster_stream_source;

    localparam int DW    = 8;
    localparam int HA    = 12;
    localparam int HT    = 16;
    localparam int VA    = 6;
    localparam int VT    = 9;
    localparam int SW    = 6;
    localparam int FRAME = HT * VT;
    localparam int BOUND = 4000;

    logic          clock = 1'b0;
    logic          reset;
    logic          enable;
    logic [DW-1:0] pix_in;
    logic          pix_in_valid;
    logic          pix_in_ready;
    logic [DW-1:0] dout;
    logic          blanking_out;
    logic          validout;
    logic          sof;
    logic          eof;
    logic          busy;
    logic [SW-1:0] stall_cycles;

    raster_stream_source #(
        .DATA_WIDTH (DW),
        .H_ACTIVE   (HA),
        .H_TOTAL    (HT),
        .V_ACTIVE   (VA),
        .V_TOTAL    (VT),
        .STALL_W    (SW)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .enable       (enable),
        .pix_in       (pix_in),
        .pix_in_valid (pix_in_valid),
        .pix_in_ready (pix_in_ready),
        .dout         (dout),
        .blanking_out (blanking_out),
        .validout     (validout),
        .sof          (sof),
        .eof          (eof),
        .busy         (busy),
        .stall_cycles (stall_cycles)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [DW-1:0] dout;
        logic          blank;
        logic          sof;
        logic          eof;
        int            pre_gap;  // required idle cycles before this beat, -1 = any
        int            stall;    // required stall_cycles on this beat, -1 = any
    } exp_t;

    exp_t          exp_q[$];
    logic [DW-1:0] src_q[$];
    int            n_checks = 0;
    int            n_fail   = 0;
    int            beats    = 0;
    int            pushed   = 0;
    int            popped   = 0;
    int            hold_at  = -1;
    int            hold_rem = 0;
    bit            rand_gaps = 1'b0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, got, want, $time);
        end
    endtask

    // Frame model: raster order, blank outside the active window, active beats
    // carry the upstream pixels in order.
    task automatic push_frame(input bit idx_pix, input int sof_gap, input int hold_k,
                              input int hold_n, input int eof_stall);
        int   k;
        exp_t e;
        k = 0;
        if (hold_k >= 0) begin
            hold_at  = pushed + hold_k;
            hold_rem = hold_n;
        end
        for (int i = 0; i < FRAME; i++) begin
            e.blank   = ((i % HT) >= HA) || ((i / HT) >= VA);
            e.sof     = (i == 0);
            e.eof     = (i == FRAME - 1);
            e.pre_gap = (i == 0) ? sof_gap : -1;
            e.stall   = (i == FRAME - 1) ? eof_stall : -1;
            e.dout    = '0;
            if (!e.blank) begin
                e.dout = idx_pix ? DW'(k) : DW'($urandom);
                if (k == hold_k) e.pre_gap = hold_n;
                src_q.push_back(e.dout);
                pushed++;
                k++;
            end
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_beats(input int target);
        bit done;
        done = 1'b0;
        for (int c = 0; c < BOUND && !done; c++) begin
            @(negedge clock);
            #1;
            if (beats >= target) done = 1'b1;
        end
        if (!done) check("beat_timeout", 64'(beats), 64'(target));
    endtask

    // Upstream source: presents queued pixels, pops on handshake, optional gaps/hold.
    initial begin
        bit fire;
        pix_in_valid = 1'b0;
        pix_in       = '0;
        forever begin
            @(negedge clock);
            fire = pix_in_valid && pix_in_ready;
            @(posedge clock);
            #1;
            if (fire && src_q.size() > 0) begin
                void'(src_q.pop_front());
                popped++;
            end
            if (popped == hold_at && hold_rem > 0) begin
                pix_in_valid = 1'b0;
                hold_rem--;
            end else if (src_q.size() == 0) begin
                pix_in_valid = 1'b0;
            end else begin
                pix_in_valid = rand_gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
            pix_in = pix_in_valid ? src_q[0] : DW'($urandom);
        end
    end

    // Monitor: pop and compare each beat, check hold on idle cycles and ready.
    initial begin
        exp_t          e;
        int            gap;
        logic [DW-1:0] last_dout;
        logic          last_blank;
        gap = 0; last_dout = '0; last_blank = 1'b0;
        forever begin
            @(negedge clock);
            if (!reset) begin
                gap = 0; last_dout = '0; last_blank = 1'b0;
            end else begin
                if (validout) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_beat", 64'(validout), 64'(0));
                    end else begin
                        e = exp_q.pop_front();
                        check("beat", 64'({blanking_out, sof, eof, dout}),
                              64'({e.blank, e.sof, e.eof, e.dout}));
                        if (e.pre_gap >= 0) check("gap", 64'(gap), 64'(e.pre_gap));
                        if (e.sof) check("stall_clear", 64'(stall_cycles), 64'(0));
                        if (e.stall >= 0) check("stall_eof", 64'(stall_cycles), 64'(e.stall));
                        last_dout  = e.dout;
                        last_blank = e.blank;
                    end
                    beats++;
                    gap = 0;
                end else begin
                    check("hold", 64'({blanking_out, sof, eof, dout}),
                          64'({last_blank, 2'b00, last_dout}));
                    gap++;
                end
                if (!busy) check("ready_idle", 64'(pix_in_ready), 64'(0));
                else if (exp_q.size() == 0) check("busy_no_frame", 64'(busy), 64'(0));
                else check("ready", 64'(pix_in_ready), 64'(!exp_q[0].blank));
            end
        end
    end

    task automatic check_all_zero(input string name);
        check(name, 64'({dout, blanking_out, validout, sof, eof, busy, stall_cycles, pix_in_ready}), 64'(0));
    endtask

    // Scenario sequencing.
    initial begin
        int b0;
        reset = 1'b0;
        enable = 1'b0;
        repeat (3) @(negedge clock);
        check_all_zero("reset_values");
        reset = 1'b1;
        repeat (3) @(negedge clock);
        check("idle_busy", 64'({busy, validout}), 64'(0));

        // Frames 1-3 back to back: index pixels, directed stall, random gaps.
        push_frame(1'b1, -1, -1, 0, 0);
        push_frame(1'b0, 0, 30, 20, 20);
        push_frame(1'b0, -1, -1, 0, -1);
        enable = 1'b1;
        wait_beats(2 * FRAME);
        rand_gaps = 1'b1;
        push_frame(1'b0, -1, 30, 100, (1 << SW) - 1);
        wait_beats(3 * FRAME);
        rand_gaps = 1'b0;
        wait_beats(3 * FRAME + 3 * HT);
        enable = 1'b0;
        wait_beats(4 * FRAME);
        repeat (20) begin
            @(negedge clock);
            check("after_drop", 64'({validout, busy}), 64'(0));
        end

        // Frame 5: start latency, enable falling exactly at the eof beat.
        push_frame(1'b0, -1, -1, 0, 0);
        @(negedge clock);
        enable = 1'b1;
        @(negedge clock);
        check("enter_stream", 64'({busy, validout}), 64'(2'b10));
        @(negedge clock);
        check("first_beat", 64'({validout, sof}), 64'(2'b11));
        wait_beats(5 * FRAME - 1);
        enable = 1'b0;
        wait_beats(5 * FRAME);
        repeat (10) begin
            @(negedge clock);
            check("after_eof_drop", 64'({validout, busy}), 64'(0));
        end

        // Frame 6 aborted by reset, frame 7 restarts from the origin.
        b0 = beats;
        push_frame(1'b0, -1, -1, 0, -1);
        @(negedge clock);
        enable = 1'b1;
        wait_beats(b0 + 60);
        #2 reset = 1'b0;
        #1 check_all_zero("async_reset");
        enable = 1'b0;
        repeat (3) @(negedge clock);
        exp_q.delete();
        src_q.delete();
        popped = 0; pushed = 0; hold_at = -1; hold_rem = 0;
        @(negedge clock);
        reset = 1'b1;
        b0 = beats;
        push_frame(1'b0, -1, -1, 0, 0);
        @(negedge clock);
        enable = 1'b1;
        wait_beats(b0 + 5);
        enable = 1'b0;
        wait_beats(b0 + FRAME);
        repeat (5) @(negedge clock);
        check("idle_end", 64'({validout, busy}), 64'(0));
        check("scoreboard_empty", 64'(exp_q.size()), 64'(0));
        check("source_drained", 64'(src_q.size()), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/raster_stream_source.md
# raster_stream_source

- Generates the blanked raster pixel stream that the octave/DoG pipeline consumes on its `din`/`blanking_in`/`validin` inputs.
- Pulls active pixels from an upstream ready/valid source, such as a frame-buffer reader or camera FIFO, and inserts horizontal and vertical blanking positions.
- Withdraws `validout` when upstream starves, freezing raster position (a mid-frame stall).
- Sits between the pixel source and `octave`.

## Interface
Parameters:
- `DATA_WIDTH`, 8, pixel width
- `H_ACTIVE`, 400, active pixels per line
- `H_TOTAL`, 420, total positions per line (active + horizontal blanking)
- `V_ACTIVE`, 300, active lines per frame
- `V_TOTAL`, 320, total lines per frame
- `STALL_W`, 16, width of stall counter

Ports:
- `clock`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-low; all state cleared while low
- `enable`  in  1  level; start/continue frames
- `pix_in`  in  DATA_WIDTH  upstream pixel
- `pix_in_valid`  in  1  upstream pixel available
- `pix_in_ready`  out  1  combinational; block accepts `pix_in` this cycle
- `dout`  out  DATA_WIDTH  registered pixel to `octave.din`
- `blanking_out`  out  1  registered; to `octave.blanking_in`
- `validout`  out  1  registered; to `octave.validin`
- `sof`  out  1  one-cycle pulse, coincident with beat at position (0,0)
- `eof`  out  1  one-cycle pulse, coincident with beat at (H_TOTAL-1, V_TOTAL-1)
- `busy`  out  1  state != IDLE
- `stall_cycles`  out  STALL_W  saturating count of stalled cycles in current frame

## Operation
- Position is tracked as `x` in 0..H_TOTAL-1 and `y` in 0..V_TOTAL-1.
- A position is active iff `x < H_ACTIVE && y < V_ACTIVE`. Otherwise it is blank.
- States are IDLE and STREAM.
- IDLE:
  - `x=y=0`; `pix_in_ready=0`.
  - `enable=1` moves to STREAM next cycle.
- STREAM, active position:
  - `pix_in_ready=1`.
  - If `pix_in_valid`, emit the beat `dout=pix_in`, `blanking_out=0`, `validout=1`, then advance.
  - Otherwise emit a stall: `validout=0`, `dout` and `blanking_out` hold their previous values, position holds, `stall_cycles` increments and saturates at all-ones.
- STREAM, blank position:
  - `pix_in_ready=0`; upstream is never consumed.
  - Emit `dout=0`, `blanking_out=1`, `validout=1`, then advance unconditionally.
- Advance:
  - `x` increments. At `x=H_TOTAL-1`, `x` returns to 0 and `y` increments.
  - At `y=V_TOTAL-1`, `y` returns to 0.
- End of frame (beat at last position):
  - If `enable=1`, continue seamlessly with (0,0) on the next cycle.
  - Otherwise return to IDLE.
- Dropping `enable` mid-frame has no effect until end of frame; frames are never truncated.
- `stall_cycles` clears on the same edge that emits `sof`, then counts stalls in that frame.
- `busy=1` in STREAM.

## Timing
- Reset values: `dout=0`, `blanking_out=0`, `validout=0`, `sof=0`, `eof=0`, `busy=0`, `stall_cycles=0`; state IDLE, `x=y=0`.
- Latency: a pixel accepted at edge N appears on `dout` with `validout=1` after edge N (1 cycle).
- First beat of a frame appears 2 cycles after `enable` rises in IDLE: 1 cycle to enter STREAM, then 1 cycle output register.
- An unstalled frame is exactly `H_TOTAL*V_TOTAL` (134400) consecutive `validout=1` cycles.
- Of those beats, 120000 have `blanking_out=0`.
- Blank beats per line are columns 400..419. Rows 300..319 are entirely blank.
- Stalls occur only at active positions. Blank beats never stall.
- Simultaneous events:
  - `enable` falling on the eof beat: go to IDLE; no further beats.
  - `pix_in_valid` high during blanking: ignored, not consumed.
- Reset asserted mid-frame: outputs drop to reset values asynchronously; the next frame restarts at (0,0).

## Structure
- The shared video package holds the default geometry constants (400/420/300/320), `DATA_WIDTH`, and a raster position struct. `octave` and its bench use the same constants.
- Sub-module `raster_counter`: `x`/`y` counters with advance input, active and last-position flags. It is reusable by a future stream sink.
- The top holds the FSM, the output register and `stall_cycles`.

## Test plan
- Reset, `enable=1`, upstream always valid with `pix_in = index mod 256`:
  - 134400 consecutive valid beats.
  - `blanking_out=1` exactly at `x>=400` or `y>=300`.
  - Active `dout` sequence is 0,1,2,...
  - `sof` on beat 0, `eof` on beat 134399, `stall_cycles=0`.
- Upstream deasserts `pix_in_valid` for 37000 cycles at active pixel 45000:
  - `validout=0` for exactly those cycles, then output resumes with pixel 45000.
  - `stall_cycles=37000`; the frame stays otherwise bit-identical.
- `pix_in_valid=1` throughout blanking: `pix_in_ready=0` at blank positions; no upstream pixel lost or duplicated (scoreboard count 120000 per frame).
- `enable` dropped at row 150: frame completes to eof, then `validout=0` and `busy=0` for 1000 cycles.
- Back-to-back frames: sof of frame 2 immediately follows eof of frame 1 (0 gap cycles); `stall_cycles` cleared.
- Reset pulled low at beat 60000: all outputs 0 immediately. After release plus `enable`, the first beat is at (0,0) with `sof=1`.
